// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR controller.
//   - Data, coefficient and output widths (Q1.15 in, Q3.15 out).
//   - FSM state encoding.
//   - Saturation limits, used when FIR_SAT_EN is defined.
package fir_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned OUT_W  = 18;
  localparam int unsigned FRAC_W = 15;
  localparam int unsigned PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } fir_state_e;

  localparam logic [OUT_W-1:0] SAT_POS = 18'h1FFFF;
  localparam logic [OUT_W-1:0] SAT_NEG = 18'h20000;

endpackage

// File: rtl/fir_tdm_mac.sv
// Shared multiply-accumulate datapath for the TDM FIR.
//   clk_i     clock
//   rst_ni    asynchronous reset, active low
//   clear_i   zero the accumulator (wins over en_i)
//   en_i      add sample_i * coef_i into the accumulator
//   sample_i  signed Q1.15 sample
//   coef_i    signed Q1.15 coefficient
//   acc_o     registered accumulator, signed, AccW bits
module fir_tdm_mac
  import fir_pkg::*;
#(
  parameter int unsigned AccW = 34
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [AccW-1:0]   acc_o
);

  logic signed [PROD_W-1:0] prod;
  logic signed [AccW-1:0]   acc_d, acc_q;

  assign prod = sample_i * coef_i;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      // Guard bits make the sum of NTAPS full-scale products overflow-free.
      acc_d = acc_q + {{(AccW - PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_tdm_ctrl.sv
// Time-multiplexed FIR controller: one shared multiplier/accumulator walks
// NTAPS taps per accepted sample (IDLE -> MAC -> OUT -> IDLE).
// Optional feature: define FIR_SAT_EN to saturate the Q3.15 output instead of
// wrapping.
//   clk          clock
//   i_rst        asynchronous reset, active low
//   i_x/i_valid  input sample stream (Q1.15); o_ready high in IDLE
//   o_y/o_valid  output stream (Q3.15); i_ready acknowledges
//   i_coef_*     coefficient bank write port, honoured only in IDLE
//   o_busy       high whenever not IDLE
module fir_tdm_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS   = 4,
  parameter int unsigned COEF_AW = 2
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [OUT_W-1:0]         o_y,
  output logic                     o_valid,
  input  logic                     i_ready,
  input  logic                     i_coef_we,
  input  logic [COEF_AW-1:0]       i_coef_addr,
  input  logic signed [COEF_W-1:0] i_coef_data,
  output logic                     o_busy
);

  localparam int unsigned AccW = PROD_W + COEF_AW;

  fir_state_e               state_d, state_q;
  logic                     ready_d, ready_q;
  logic                     valid_d, valid_q;
  logic [OUT_W-1:0]         y_d, y_q;
  // One extra bit: k == NTAPS marks the cycle where the final sum is read out.
  logic [COEF_AW:0]         k_d, k_q;
  logic [COEF_AW-1:0]       wr_ptr_d, wr_ptr_q;
  logic signed [DATA_W-1:0] dly_d [NTAPS];
  logic signed [DATA_W-1:0] dly_q [NTAPS];
  logic signed [COEF_W-1:0] coef_d [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];

  logic                     accept;
  logic                     mac_en;
  logic [COEF_AW-1:0]       tap;
  logic [COEF_AW-1:0]       rd_idx;
  logic signed [AccW-1:0]   acc;

  function automatic logic [OUT_W-1:0] scale(input logic signed [AccW-1:0] a);
`ifdef FIR_SAT_EN
    logic [AccW-OUT_W-FRAC_W:0] hi;
    // In range only if every bit above the Q3.15 sign bit matches it.
    hi = a[AccW-1:OUT_W+FRAC_W-1];
    if (hi != '0 && hi != '1) begin
      return a[AccW-1] ? SAT_NEG : SAT_POS;
    end
`endif
    return a[OUT_W+FRAC_W-1:FRAC_W];
  endfunction

  // ready_q is only ever set in IDLE, so it alone qualifies acceptance.
  assign accept = ready_q && i_valid;
  assign tap    = k_q[COEF_AW-1:0];
  assign rd_idx = wr_ptr_q - tap;
  assign mac_en = (state_q == StMac) && !k_q[COEF_AW];

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    y_d      = y_q;
    k_d      = k_q;
    wr_ptr_d = wr_ptr_q;
    dly_d    = dly_q;
    coef_d   = coef_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dly_d[wr_ptr_q] = i_x;
          k_d             = '0;
          state_d         = StMac;
        end else if (i_coef_we) begin
          coef_d[i_coef_addr] = i_coef_data;
        end
      end
      StMac: begin
        if (k_q[COEF_AW]) begin
          y_d     = scale(acc);
          valid_d = 1'b1;
          state_d = StOut;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StOut: begin
        if (i_ready) begin
          valid_d  = 1'b0;
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered so o_ready stays low until the first edge after reset release.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      y_q      <= '0;
      k_q      <= '0;
      wr_ptr_q <= '0;
      dly_q    <= '{default: '0};
      coef_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      y_q      <= y_d;
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
      dly_q    <= dly_d;
      coef_q   <= coef_d;
    end
  end

  fir_tdm_mac #(
    .AccW(AccW)
  ) u_mac (
    .clk_i   (clk),
    .rst_ni  (i_rst),
    .clear_i (accept),
    .en_i    (mac_en),
    .sample_i(dly_q[rd_idx]),
    .coef_i  (coef_q[tap]),
    .acc_o   (acc)
  );

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_y     = y_q;
  assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_fir_tdm_ctrl.sv
// Self-checking bench for fir_tdm_ctrl (NTAPS = 4). The reference model keeps
// the last NTAPS accepted samples and the coefficient bank in plain arrays and
// forms the dot product with integer arithmetic.
module tb_fir_tdm_ctrl;

  localparam int NTAPS = 4;
  localparam int LAT   = NTAPS + 1;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic signed [15:0] i_x = '0;
  logic               i_valid = 1'b0;
  logic               o_ready;
  logic [17:0]        o_y;
  logic               o_valid;
  logic               i_ready = 1'b0;
  logic               i_coef_we = 1'b0;
  logic [1:0]         i_coef_addr = '0;
  logic signed [15:0] i_coef_data = '0;
  logic               o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] hist [NTAPS];
  logic signed [15:0] mcoef[NTAPS];

  fir_tdm_ctrl #(
    .NTAPS  (4),
    .COEF_AW(2)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_x        (i_x),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_y        (o_y),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .i_coef_we  (i_coef_we),
    .i_coef_addr(i_coef_addr),
    .i_coef_data(i_coef_data),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < NTAPS; i++) begin
      hist[i]  = '0;
      mcoef[i] = '0;
    end
  endfunction

  function automatic void model_push(input logic signed [15:0] x);
    for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endfunction

  function automatic logic [17:0] model_y();
    longint      sum;
    logic [63:0] bits;
    sum = 0;
    for (int i = 0; i < NTAPS; i++) sum += longint'(mcoef[i]) * longint'(hist[i]);
`ifdef FIR_SAT_EN
    if (sum >= 64'sd4294967296) return 18'h1FFFF;
    if (sum < -64'sd4294967296) return 18'h20000;
`endif
    bits = sum;
    return bits[32:15];
  endfunction

  // ---------------- drivers ----------------
  task automatic write_coef(input logic [1:0] addr, input logic signed [15:0] data);
    @(negedge clk);
    i_coef_we   = 1'b1;
    i_coef_addr = addr;
    i_coef_data = data;
    @(negedge clk);
    i_coef_we   = 1'b0;
    mcoef[addr] = data;
  endtask

  // Offers x, waits for acceptance, then counts edges to o_valid. With busy_wr
  // a write of 0 to tap 0 is held from the accept cycle into MAC.
  task automatic start_sample(input logic signed [15:0] x, input bit busy_wr,
                              output int lat);
    int n;
    @(negedge clk);
    i_x     = x;
    i_valid = 1'b1;
    if (busy_wr) begin
      i_coef_we   = 1'b1;
      i_coef_addr = 2'd0;
      i_coef_data = 16'sh0000;
    end
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!o_ready) begin
      $display("FAIL accept_timeout: o_ready=%b required 1", o_ready);
      n_fail++;
      i_valid   = 1'b0;
      i_coef_we = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_x     = 16'($urandom);
    model_push(x);
    lat = 0;
    while (!o_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat >= 2) i_coef_we = 1'b0;
    end
    i_coef_we = 1'b0;
    n_checks++;
    if (!o_valid) begin
      $display("FAIL output_timeout: o_valid=%b required 1", o_valid);
      n_fail++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    #2;
    i_rst = 1'b0;
    #1;
    n_checks += 4;
    if (o_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", o_valid); n_fail++; end
    if (o_y !== 18'h0) begin $display("FAIL reset_y: got %h want 0", o_y); n_fail++; end
    if (o_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", o_ready); n_fail++; end
    if (o_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", o_busy); n_fail++; end
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 1'b0) begin $display("FAIL ready_before_edge: got %b want 0", o_ready); n_fail++; end
    @(posedge clk);
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin $display("FAIL ready_after_edge: got %b want 1", o_ready); n_fail++; end
  endtask

  task automatic test_impulse();
    logic [17:0]        exp_tab[5] = '{18'h03FFF, 18'h03FFF, 18'h03FFF, 18'h03FFF, 18'h00000};
    logic signed [15:0] xs[5]      = '{16'sh7FFF, 16'sh0, 16'sh0, 16'sh0, 16'sh0};
    int lat;
    for (int i = 0; i < NTAPS; i++) write_coef(2'(i), 16'sh4000);
    for (int i = 0; i < 5; i++) begin
      start_sample(xs[i], 1'b0, lat);
      n_checks += 2;
      if (o_y !== exp_tab[i]) begin
        $display("FAIL impulse[%0d]: o_y=%h required %h", i, o_y, exp_tab[i]); n_fail++;
      end
      if (o_y !== model_y()) begin
        $display("FAIL impulse_model[%0d]: o_y=%h required %h", i, o_y, model_y()); n_fail++;
      end
      ack();
    end
  endtask

  task automatic test_overflow();
`ifdef FIR_SAT_EN
    logic [17:0] exp_tab[4] = '{18'h08000, 18'h10000, 18'h18000, 18'h1FFFF};
`else
    logic [17:0] exp_tab[4] = '{18'h08000, 18'h10000, 18'h18000, 18'h20000};
`endif
    int lat;
    for (int i = 0; i < NTAPS; i++) write_coef(2'(i), 16'sh8000);
    for (int i = 0; i < 4; i++) begin
      start_sample(16'sh8000, 1'b0, lat);
      n_checks++;
      if (o_y !== exp_tab[i]) begin
        $display("FAIL overflow[%0d]: o_y=%h required %h", i, o_y, exp_tab[i]); n_fail++;
      end
      ack();
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] y_exp;
    int lat;
    for (int i = 0; i < NTAPS; i++) write_coef(2'(i), 16'($urandom));
    start_sample(16'($urandom), 1'b0, lat);
    y_exp = model_y();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      i_valid     = c[0];
      i_x         = 16'($urandom);
      i_coef_we   = 1'b1;
      i_coef_addr = 2'(c);
      i_coef_data = 16'($urandom);
      #1;
      n_checks += 4;
      if (o_valid !== 1'b1) begin $display("FAIL bp_valid[%0d]: got %b want 1", c, o_valid); n_fail++; end
      if (o_y !== y_exp) begin $display("FAIL bp_y[%0d]: got %h want %h", c, o_y, y_exp); n_fail++; end
      if (o_ready !== 1'b0) begin $display("FAIL bp_ready[%0d]: got %b want 0", c, o_ready); n_fail++; end
      if (o_busy !== 1'b1) begin $display("FAIL bp_busy[%0d]: got %b want 1", c, o_busy); n_fail++; end
    end
    i_valid   = 1'b0;
    i_coef_we = 1'b0;
    ack();
    n_checks += 2;
    if (o_valid !== 1'b0) begin $display("FAIL bp_release: o_valid=%b want 0", o_valid); n_fail++; end
    if (o_ready !== 1'b1) begin $display("FAIL bp_idle: o_ready=%b want 1", o_ready); n_fail++; end
    // A stray i_ready in IDLE must not advance the delay line.
    ack();
    start_sample(16'($urandom), 1'b0, lat);
    n_checks++;
    if (o_y !== model_y()) begin $display("FAIL bp_stray_ready: o_y=%h want %h", o_y, model_y()); n_fail++; end
    ack();
  endtask

  task automatic test_coef_busy();
    int lat;
    for (int i = 0; i < NTAPS; i++) write_coef(2'(i), 16'sh4000);
    start_sample(16'($urandom), 1'b1, lat);
    n_checks++;
    if (o_y !== model_y()) begin $display("FAIL coef_busy_now: o_y=%h want %h", o_y, model_y()); n_fail++; end
    ack();
    start_sample(16'sh7FFF, 1'b0, lat);
    n_checks++;
    if (o_y !== model_y()) begin $display("FAIL coef_busy_next: o_y=%h want %h", o_y, model_y()); n_fail++; end
    ack();
  endtask

  task automatic test_reset_mid();
    int lat;
    for (int i = 0; i < NTAPS; i++) write_coef(2'(i), 16'($urandom_range(16'h7FFF, 16'h1000)));
    @(negedge clk);
    i_x     = 16'sh7FFF;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    #1;
    model_clear();
    n_checks += 4;
    if (o_valid !== 1'b0) begin $display("FAIL mid_valid: got %b want 0", o_valid); n_fail++; end
    if (o_y !== 18'h0) begin $display("FAIL mid_y: got %h want 0", o_y); n_fail++; end
    if (o_busy !== 1'b0) begin $display("FAIL mid_busy: got %b want 0", o_busy); n_fail++; end
    if (o_ready !== 1'b0) begin $display("FAIL mid_ready: got %b want 0", o_ready); n_fail++; end
    @(negedge clk);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 2;
    if (o_ready !== 1'b1) begin $display("FAIL mid_ready_rise: got %b want 1", o_ready); n_fail++; end
    if (o_valid !== 1'b0) begin $display("FAIL mid_no_emit: got %b want 0", o_valid); n_fail++; end
    for (int i = 0; i < NTAPS; i++) write_coef(2'(i), 16'($urandom));
    for (int i = 0; i < NTAPS; i++) begin
      start_sample((i == 0) ? 16'sh7FFF : 16'sh0, 1'b0, lat);
      n_checks++;
      if (o_y !== model_y()) begin
        $display("FAIL mid_after[%0d]: o_y=%h want %h", i, o_y, model_y()); n_fail++;
      end
      ack();
    end
  endtask

  task automatic test_latency();
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_sample(16'($urandom), 1'b0, lat);
      n_checks++;
      if (lat != LAT) begin $display("FAIL latency[%0d]: got %0d want %0d", i, lat, LAT); n_fail++; end
      ack();
    end
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(1, 0) == 1) write_coef(2'($urandom), 16'($urandom));
      start_sample(16'($urandom), 1'b0, lat);
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
      n_checks++;
      if (o_y !== model_y()) begin
        $display("FAIL random[%0d]: o_y=%h want %h", i, o_y, model_y()); n_fail++;
      end
      ack();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_impulse();
    test_overflow();
    test_backpressure();
    test_coef_busy();
    test_reset_mid();
    test_latency();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
